// File: rtl/dim_readout_seq.sv
// dim_readout_seq: sequencer for one QSPI DIM readout line.
// Optional engine timeout in WAIT: define DIM_SEQ_TIMEOUT_EN.
module dim_readout_seq #(
   parameter int CLK_PER_US = 40,
   parameter int RST_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reset_i,
   input  logic        trig_i,
   input  logic [3:0]  last_reg_adr_i,
   input  logic [3:0]  max_dim_no_i,
   input  logic [9:0]  read_delay_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_many_o,
   output logic        err_fb_o,
   output logic        err_ovf_o,
   output logic        err_tmo_o,
   output logic [3:0]  dim_count_o,
   output logic        dim_rst_o,
   output logic        rd_req_o,
   output logic [3:0]  rd_reg_o,
   output logic [3:0]  rd_dev_o,
   input  logic        rd_ack_i,
   input  logic [15:0] rd_data_i,
   input  logic        rd_last_i,
   input  logic        rd_fb_err_i,
   output logic        mem_we_o,
   output logic [6:0]  mem_addr_o,
   output logic [15:0] mem_data_o
);
   localparam int DLY_MAX = 1023 * CLK_PER_US;
   localparam int CNT_MAX = (DLY_MAX > RST_CYCLES) ? DLY_MAX : RST_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] US_CLKS = CW'(CLK_PER_US);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRST, S_REQ, S_WAIT, S_DELAY, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    last_q, last_d, max_q, max_d;
   logic [9:0]    rdly_q, rdly_d;
   logic [3:0]    reg_q, reg_d, dev_q, dev_d;
   logic [7:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d, many_q, many_d;
   logic          fb_q, fb_d, ovf_q, ovf_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic          we_q, we_d;
   logic [6:0]    addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic [4:0]    dev_inc;
   logic [CW-1:0] dly_clks;
   logic          go_drst, tmo_hit;

   assign dev_inc  = {1'b0, dev_q} + 5'd1;
   assign dly_clks = CW'(rdly_q) * US_CLKS;
   assign go_drst  = reset_i &&
      (state_q inside {S_IDLE, S_REQ, S_WAIT, S_DELAY});

`ifdef DIM_SEQ_TIMEOUT_EN
   logic [15:0] tcnt_q, tcnt_d;
   logic        tmo_q, tmo_d, tmo_clr;

   assign tmo_clr = go_drst || (state_q == S_IDLE && trig_i);
   assign tmo_hit = (state_q == S_WAIT) && !reset_i &&
      !rd_ack_i && (tcnt_q == 16'hFFFE);

   // Count WAIT cycles without an ack; flag a stalled engine.
   always_comb begin
      tcnt_d = (state_q == S_WAIT) ? tcnt_q + 16'd1 : 16'd0;
      tmo_d  = tmo_q;
      if (tmo_clr) tmo_d = 1'b0;
      if (tmo_hit) tmo_d = 1'b1;
   end

   // Timeout counter and sticky flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tmo_q  <= tmo_d;
      end
   end

   assign err_tmo_o = tmo_q;
`else
   assign tmo_hit   = 1'b0;
   assign err_tmo_o = 1'b0;
`endif

   // Next-state, sequencing counters, status flags and SRAM write.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      max_d   = max_q;
      rdly_d  = rdly_q;
      reg_d   = reg_q;
      dev_d   = dev_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      many_d  = many_q;
      fb_d    = fb_q;
      ovf_d   = ovf_q;
      dcnt_d  = dcnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (go_drst) begin
         state_d = S_DRST;
         cnt_d   = RST_LOAD;
         done_d  = 1'b0;
         many_d  = 1'b0;
         fb_d    = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (trig_i) begin
                  last_d = last_reg_adr_i;
                  max_d  = max_dim_no_i;
                  rdly_d = read_delay_i;
                  done_d = 1'b0;
                  many_d = 1'b0;
                  fb_d   = 1'b0;
                  ovf_d  = 1'b0;
                  dcnt_d = '0;
                  ptr_d  = '0;
                  reg_d  = '0;
                  dev_d  = '0;
                  if (max_dim_no_i == 4'd0) begin
                     many_d  = 1'b1;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_DRST: begin
               if (cnt_q == '0) state_d = S_IDLE;
               else cnt_d = cnt_q - ONE;
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
               if (rd_ack_i) begin
                  if (ptr_q[7]) begin
                     ovf_d = 1'b1;
                  end else begin
                     we_d   = 1'b1;
                     addr_d = ptr_q[6:0];
                     data_d = rd_data_i;
                     ptr_d  = ptr_q + 8'd1;
                  end
                  if (rd_fb_err_i) begin
                     fb_d    = 1'b1;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (!rd_last_i) begin
                     if (dev_inc == {1'b0, max_q}) begin
                        many_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        dev_d   = dev_q + 4'd1;
                        state_d = S_REQ;
                     end
                  end else begin
                     if (reg_q == 4'd0) dcnt_d = dev_inc[3:0];
                     if (reg_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        dev_d   = '0;
                        reg_d   = reg_q + 4'd1;
                        cnt_d   = dly_clks;
                        state_d = S_DELAY;
                     end
                  end
               end else if (tmo_hit) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_DELAY: begin
               if (cnt_q <= ONE) state_d = S_REQ;
               else cnt_d = cnt_q - ONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         last_q  <= '0;
         max_q   <= '0;
         rdly_q  <= '0;
         reg_q   <= '0;
         dev_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         many_q  <= 1'b0;
         fb_q    <= 1'b0;
         ovf_q   <= 1'b0;
         dcnt_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         max_q   <= max_d;
         rdly_q  <= rdly_d;
         reg_q   <= reg_d;
         dev_q   <= dev_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         many_q  <= many_d;
         fb_q    <= fb_d;
         ovf_q   <= ovf_d;
         dcnt_q  <= dcnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign err_many_o  = many_q;
   assign err_fb_o    = fb_q;
   assign err_ovf_o   = ovf_q;
   assign dim_count_o = dcnt_q;
   assign dim_rst_o   = (state_q == S_DRST);
   assign rd_req_o    = (state_q == S_REQ) || (state_q == S_WAIT);
   assign rd_reg_o    = reg_q;
   assign rd_dev_o    = dev_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_data_o  = data_q;
endmodule

// File: tb/tb_dim_readout_seq.sv
// tb_dim_readout_seq: randomized word engine against a
// readout-count model of the DIM line sequencer.
module tb_dim_readout_seq;
   localparam int CLK_PER_US = 40;
   localparam int RST_CYCLES = 1000;

   logic        clk = 1'b0;
   logic        rst_i, reset_i, trig_i;
   logic [3:0]  last_reg_adr_i, max_dim_no_i;
   logic [9:0]  read_delay_i;
   logic        busy_o, done_o, err_many_o, err_fb_o;
   logic        err_ovf_o, err_tmo_o, dim_rst_o, rd_req_o;
   logic [3:0]  dim_count_o, rd_reg_o, rd_dev_o;
   logic        rd_ack_i, rd_last_i, rd_fb_err_i;
   logic [15:0] rd_data_i;
   logic        mem_we_o;
   logic [6:0]  mem_addr_o;
   logic [15:0] mem_data_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [22:0] wr_q[$];
   logic [15:0] sent[$];
   int gaps[$];

   dim_readout_seq #(
      .CLK_PER_US(CLK_PER_US),
      .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .reset_i(reset_i),
      .trig_i(trig_i), .last_reg_adr_i(last_reg_adr_i),
      .max_dim_no_i(max_dim_no_i), .read_delay_i(read_delay_i),
      .busy_o(busy_o), .done_o(done_o),
      .err_many_o(err_many_o), .err_fb_o(err_fb_o),
      .err_ovf_o(err_ovf_o), .err_tmo_o(err_tmo_o),
      .dim_count_o(dim_count_o), .dim_rst_o(dim_rst_o),
      .rd_req_o(rd_req_o), .rd_reg_o(rd_reg_o),
      .rd_dev_o(rd_dev_o), .rd_ack_i(rd_ack_i),
      .rd_data_i(rd_data_i), .rd_last_i(rd_last_i),
      .rd_fb_err_i(rd_fb_err_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (mem_we_o) wr_q.push_back({mem_addr_o, mem_data_o});

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outcome of one readout from the line rules: words per pass,
   // device limit, first feedback error.
   function automatic void model(input int L, input int mx,
      input int ndev, input int fb_at, output int nw,
      output bit many, output bit fb, output int dcnt);
      int normal;
      bit many_n;
      nw = 0; many = 0; fb = 0; dcnt = 0;
      if (mx == 0) begin
         many = 1;
         return;
      end
      many_n = (ndev == 0) || (ndev > mx);
      normal = many_n ? mx : (L + 1) * ndev;
      if (fb_at != 0 && fb_at <= normal) begin
         nw = fb_at;
         fb = 1;
      end else begin
         nw = normal;
         many = many_n;
      end
      if (!many_n && (fb_at == 0 || fb_at > ndev)) dcnt = ndev;
   endfunction

   task automatic serve(input int ndev, input int fb_at,
                        output int nacks);
      int budget, r, d, lat, ack_cyc;
      bit last, wait_gap;
      budget = 20000; r = 0; d = 0; nacks = 0;
      wait_gap = 0; ack_cyc = 0;
      while (busy_o && budget > 0) begin
         if (rd_req_o) begin
            if (wait_gap) begin
               gaps.push_back(cyc - ack_cyc - 1);
               wait_gap = 0;
            end
            chk("rd_reg", rd_reg_o, r);
            chk("rd_dev", rd_dev_o, d);
            lat = $urandom_range(1, 3);
            repeat (lat) @(negedge clk);
            budget -= lat;
            last = (ndev != 0) && (d == ndev - 1);
            rd_ack_i = 1;
            rd_data_i = 16'($urandom);
            rd_last_i = last;
            rd_fb_err_i = (nacks + 1 == fb_at);
            sent.push_back(rd_data_i);
            nacks++;
            ack_cyc = cyc;
            if (last) begin
               d = 0; r++; wait_gap = 1;
            end else d++;
            @(negedge clk);
            rd_ack_i = 0; rd_last_i = 0; rd_fb_err_i = 0;
         end else @(negedge clk);
         budget--;
      end
      chk("idle_after_readout", busy_o, 0);
   endtask

   task automatic readout(input string nm, input int L, input int mx,
      input int ndev, input int dly, input int fb_at);
      int nacks, nw, dcnt, nexp, dexp;
      bit many, fb;
      sent.delete(); wr_q.delete(); gaps.delete();
      trig_i = 1;
      last_reg_adr_i = 4'(L);
      max_dim_no_i = 4'(mx);
      read_delay_i = 10'(dly);
      @(negedge clk);
      trig_i = 0;
      last_reg_adr_i = 4'($urandom);
      max_dim_no_i = 4'($urandom);
      read_delay_i = 10'($urandom_range(0, 3));
      serve(ndev, fb_at, nacks);
      model(L, mx, ndev, fb_at, nw, many, fb, dcnt);
      nexp = (nw > 128) ? 128 : nw;
      dexp = (dly == 0) ? 1 : dly * CLK_PER_US;
      chk({nm, ".acks"}, nacks, nw);
      chk({nm, ".writes"}, wr_q.size(), nexp);
      for (int i = 0; i < wr_q.size() && i < nexp; i++)
         chk($sformatf("%s.wr%0d", nm, i), wr_q[i], {i[6:0], sent[i]});
      foreach (gaps[i])
         chk($sformatf("%s.gap%0d", nm, i), gaps[i], dexp);
      chk({nm, ".done"}, done_o, 1);
      chk({nm, ".many"}, err_many_o, many);
      chk({nm, ".fb"}, err_fb_o, fb);
      chk({nm, ".ovf"}, err_ovf_o, nw > 128);
      chk({nm, ".tmo"}, err_tmo_o, 0);
      chk({nm, ".dcnt"}, dim_count_o, dcnt);
   endtask

   initial begin
      int n, L, mx, nd, dl, fa;
      rst_i = 1; reset_i = 0; trig_i = 0;
      last_reg_adr_i = 0; max_dim_no_i = 0; read_delay_i = 0;
      rd_ack_i = 0; rd_data_i = 16'hBEEF;
      rd_last_i = 0; rd_fb_err_i = 0;
      repeat (3) @(negedge clk);
      chk("rst.busy", busy_o, 0);
      chk("rst.done", done_o, 0);
      chk("rst.many", err_many_o, 0);
      chk("rst.fb", err_fb_o, 0);
      chk("rst.ovf", err_ovf_o, 0);
      chk("rst.tmo", err_tmo_o, 0);
      chk("rst.dcnt", dim_count_o, 0);
      chk("rst.dim_rst", dim_rst_o, 0);
      chk("rst.rd_req", rd_req_o, 0);
      chk("rst.rd_reg", rd_reg_o, 0);
      chk("rst.rd_dev", rd_dev_o, 0);
      chk("rst.we", mem_we_o, 0);
      chk("rst.addr", mem_addr_o, 0);
      chk("rst.data", mem_data_o, 0);
      rst_i = 0;
      @(negedge clk);

      readout("bringup", 1, 4, 3, 2, 0);
      chk("bringup.gaps", gaps.size(), 1);
      readout("dly0", 1, 4, 2, 0, 0);
      chk("dly0.gaps", gaps.size(), 1);
      readout("many2", 0, 2, 0, 0, 0);
      readout("max0", 0, 0, 3, 0, 0);
      readout("fb2", 2, 4, 3, 0, 2);
      readout("ovf", 15, 15, 15, 0, 0);
      for (int k = 0; k < 8; k++) begin
         L = $urandom_range(0, 3);
         mx = $urandom_range(1, 15);
         nd = $urandom_range(0, 15);
         dl = $urandom_range(0, 1);
         fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
         readout($sformatf("rnd%0d", k), L, mx, nd, dl, fa);
      end

      sent.delete(); wr_q.delete();
      trig_i = 1; last_reg_adr_i = 1; max_dim_no_i = 4;
      @(negedge clk);
      trig_i = 0;
      chk("abort.req_in_req", rd_req_o, 1);
      @(negedge clk);
      chk("abort.req_in_wait", rd_req_o, 1);
      reset_i = 1;
      @(negedge clk);
      reset_i = 0;
      chk("abort.req_drop", rd_req_o, 0);
      chk("abort.dim_rst", dim_rst_o, 1);
      n = 0;
      while (dim_rst_o && n < 2 * RST_CYCLES) begin
         n++;
         rd_ack_i = (n == 1);
         rd_last_i = (n == 1);
         trig_i = (n == 5);
         @(negedge clk);
      end
      rd_ack_i = 0; rd_last_i = 0; trig_i = 0;
      chk("abort.rst_len", n, RST_CYCLES);
      chk("abort.idle", busy_o, 0);
      chk("abort.done", done_o, 0);
      chk("abort.writes", wr_q.size(), 0);
      repeat (2) @(negedge clk);
      chk("abort.trig_ignored", rd_req_o, 0);

      reset_i = 1; trig_i = 1;
      @(negedge clk);
      reset_i = 0; trig_i = 0;
      chk("rst_trig.dim_rst", dim_rst_o, 1);
      chk("rst_trig.req", rd_req_o, 0);
      n = 0;
      while (dim_rst_o && n < 2 * RST_CYCLES) begin
         n++;
         @(negedge clk);
      end
      chk("rst_trig.rst_len", n, RST_CYCLES);
      chk("rst_trig.idle", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dim_readout_seq.md
Name: dim_readout_seq

Overview:
- Sequencer for one QSPI DIM readout line.
- Takes the per-line control fields (reset, trig, last_reg_adr, max_dim_no, read_delay) from the register bank and drives the status fields (busy, done, err_many, err_fb, dim_count).
- Orders word reads from the QSPI word engine and writes each returned 16-bit word linearly into the 128x16 readout SRAM that the bus reads back.
- One instance per DIM line.

Parameters:
- CLK_PER_US, 40: clock cycles per microsecond; sets the read_delay prescaler.
- RST_CYCLES, 1000: length of the DIM reset pulse, in clocks.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous active-high reset.
- reset_i  in  1  single-cycle request to reset the DIM line.
- trig_i  in  1  single-cycle request to start a readout.
- last_reg_adr_i  in  4  highest DIM register index to read.
- max_dim_no_i  in  4  maximum number of devices on the line.
- read_delay_i  in  10  delay between register passes, in µs.
- busy_o  out  1  high in RESET and all readout states.
- done_o  out  1  sticky: readout finished.
- err_many_o  out  1  sticky: more devices than max_dim_no.
- err_fb_o  out  1  sticky: feedback error reported by the engine.
- err_ovf_o  out  1  sticky: more than 128 words returned; excess dropped.
- err_tmo_o  out  1  sticky: engine timeout (feature only, otherwise 0).
- dim_count_o  out  4  devices detected on register pass 0.
- dim_rst_o  out  1  DIM reset level driven to the QSPI engine.
- rd_req_o  out  1  word request; held until rd_ack_i.
- rd_reg_o  out  4  register index of the request.
- rd_dev_o  out  4  device index of the request.
- rd_ack_i  in  1  one-cycle word-valid strobe.
- rd_data_i  in  16  returned word.
- rd_last_i  in  1  returned word is from the last device in the chain.
- rd_fb_err_i  in  1  feedback error, valid with rd_ack_i.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  7  SRAM write address.
- mem_data_o  out  16  SRAM write data.

Behaviour:
- Reset (rst_i=1):
  - State goes to IDLE.
  - All outputs are 0 (dim_count_o=0, mem_addr_o=0).
  - Write pointer and counters are cleared.
- States: IDLE, DRST, REQ, WAIT, DELAY, DONE.
- IDLE:
  - reset_i goes to DRST.
  - Otherwise trig_i latches last_reg_adr, max_dim_no and read_delay.
  - trig_i clears done, all err flags, dim_count and the write pointer; reg=0, dev=0.
  - If the latched max_dim_no=0: err_many=1, next state DONE, no requests issued.
  - Otherwise next state REQ.
  - If reset_i and trig_i arrive in the same cycle, reset_i wins.
- DRST:
  - dim_rst_o=1 for exactly RST_CYCLES clocks, then IDLE.
  - done and err flags are cleared on entry.
- REQ:
  - rd_req_o=1 with rd_reg_o=reg and rd_dev_o=dev; next state WAIT.
  - rd_req_o stays high through WAIT until the cycle rd_ack_i is sampled.
- WAIT, on rd_ack_i:
  - If the write pointer is below 128: one-cycle mem_we_o with mem_addr_o=pointer and mem_data_o=rd_data_i; pointer increments.
  - At 128 the write is suppressed and err_ovf is set; the pointer saturates and does not wrap.
  - rd_fb_err_i=1 sets err_fb and aborts to DONE (the word is still written).
  - If rd_last_i=0 and dev+1 = max_dim_no: err_many=1, abort to DONE.
  - If rd_last_i=0 otherwise: dev+1, back to REQ.
  - If rd_last_i=1 and reg=0: dim_count=dev+1.
  - If rd_last_i=1 and reg=last_reg_adr: go to DONE.
  - If rd_last_i=1 otherwise: dev=0, reg+1, go to DELAY.
- DELAY:
  - Waits read_delay×CLK_PER_US clocks, then REQ.
  - read_delay=0 goes to REQ on the next clock.
- DONE: done_o=1 for one state cycle, then IDLE; done_o stays sticky until the next trig_i or reset_i.
- busy_o is 1 in every state except IDLE.
- trig_i while busy is ignored.
- reset_i in REQ, WAIT or DELAY aborts the readout:
  - rd_req_o drops the next cycle and a late rd_ack_i is ignored.
  - Next state DRST; done_o is not set.
- Only the latched config is used; changing the inputs mid-readout has no effect.

Optional Feature:
- Macro DIM_SEQ_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in WAIT.
  - If 65535 clocks pass without rd_ack_i: err_tmo=1, rd_req_o drops, next state DONE.
- When undefined: WAIT blocks indefinitely, err_tmo_o is tied 0, no counter is synthesised.

Test Plan:
- Bring-up: rst_i, then trig with last_reg_adr=1, max_dim_no=4; engine returns 3 words per pass, last on dev 2 -> 6 SRAM writes at addresses 0..5, dim_count_o=3, done_o=1, no errors.
- Read delay: read_delay=2, CLK_PER_US=40 -> exactly 80 clocks from the last ack of reg 0 to rd_req_o for reg 1; read_delay=0 -> REQ on the next clock.
- Too many devices: max_dim_no=2 and the engine never asserts last -> err_many_o=1 after 2 words, done_o=1; max_dim_no=0 -> err_many_o=1 with no rd_req_o.
- Overflow: last_reg_adr=15, 15 devices (240 words) -> 128 writes only, err_ovf_o=1, pointer held at 127 region, sequence completes with done_o=1.
- Reset during readout: reset_i in WAIT -> rd_req_o low the next cycle, dim_rst_o high for RST_CYCLES, done_o=0; trig_i while busy ignored; reset_i+trig_i together -> DRST.
- Feedback error: rd_fb_err_i=1 on the 2nd ack -> err_fb_o=1, abort to DONE; with DIM_SEQ_TIMEOUT_EN and no ack -> err_tmo_o=1 after 65535 clocks.
